// File: rtl/bk_addsub_pipe.sv
// Two-stage pipelined Brent-Kung add/subtract unit with elastic valid/ready handshake.
// Stage 1 holds the group P/G up-sweep; stage 2 holds the down-sweep, sum and flags.
module bk_addsub_pipe #(
    parameter int WIDTH     = 64,
    parameter int GROUPSIZE = 8,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    input  logic             in_cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);
    localparam int NG   = WIDTH / GROUPSIZE;
    localparam int LOGN = $clog2(NG);

    // Prefix operator on {G, P} pairs: hi covers the more significant span.
    function automatic logic [1:0] gp_dot(input logic [1:0] hi, input logic [1:0] lo);
        return {hi[1] | (hi[0] & lo[1]), hi[0] & lo[0]};
    endfunction

    function automatic logic [1:0] group_gp(input logic [GROUPSIZE-1:0] gen,
                                            input logic [GROUPSIZE-1:0] prop);
        logic [1:0] acc;
        acc = 2'b01;
        for (int k = 0; k < GROUPSIZE; k++) begin
            acc = gp_dot({gen[k], prop[k]}, acc);
        end
        return acc;
    endfunction

    logic adv1, adv2;

    logic                   vld_p1_q, vld_p1_d;
    logic [WIDTH-1:0]       a_p1_q, b_p1_q;
    logic                   c0_p1_q;
    logic [TAG_W-1:0]       tag_p1_q;
    logic [NG-1:0]          up_g_p1_q, up_p_p1_q;

    logic                   vld_p2_q, vld_p2_d;
    logic [WIDTH-1:0]       sum_p2_q, sum_p2_d;
    logic                   cout_p2_q, cout_p2_d;
    logic                   ovf_p2_q, ovf_p2_d;
    logic                   zero_p2_q, zero_p2_d;
    logic [TAG_W-1:0]       tag_p2_q;

    logic [WIDTH-1:0]       b_int_p1_d;
    logic                   c0_p1_d;
    logic [NG-1:0]          up_g_p1_d, up_p_p1_d;
    logic [1:0]             grp_gp;

    logic [NG-1:0]          pre_g, pre_p, cin_grp;
    logic [WIDTH-1:0]       gen_s2, prop_s2, carry_s2;

    assign adv2     = !vld_p2_q || out_ready;
    assign adv1     = !vld_p1_q || adv2;
    assign in_ready = adv1;

    assign vld_p1_d = adv1 ? in_valid : vld_p1_q;
    assign vld_p2_d = adv2 ? vld_p1_q : vld_p2_q;

    // ---- stage 1: operand conditioning, group P/G, up-sweep ----
    always_comb begin
        b_int_p1_d = in_op ? ~in_b : in_b;
        c0_p1_d    = in_op ? ~in_cin : in_cin;
        grp_gp     = 2'b01;
        up_g_p1_d  = '0;
        up_p_p1_d  = '0;
        for (int g = 0; g < NG; g++) begin
            grp_gp = group_gp(in_a[g*GROUPSIZE +: GROUPSIZE] & b_int_p1_d[g*GROUPSIZE +: GROUPSIZE],
                              in_a[g*GROUPSIZE +: GROUPSIZE] ^ b_int_p1_d[g*GROUPSIZE +: GROUPSIZE]);
            up_g_p1_d[g] = grp_gp[1];
            up_p_p1_d[g] = grp_gp[0];
        end
        for (int l = 0; l < LOGN; l++) begin
            for (int i = 0; i < NG; i++) begin
                if (((i + 1) % (1 << (l + 1))) == 0) begin
                    {up_g_p1_d[i], up_p_p1_d[i]} = gp_dot({up_g_p1_d[i], up_p_p1_d[i]},
                        {up_g_p1_d[i-(1<<l)], up_p_p1_d[i-(1<<l)]});
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
        end
    end

    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            a_p1_q    <= in_a;
            b_p1_q    <= b_int_p1_d;
            c0_p1_q   <= c0_p1_d;
            tag_p1_q  <= in_tag;
            up_g_p1_q <= up_g_p1_d;
            up_p_p1_q <= up_p_p1_d;
        end
    end

    // ---- stage 2: down-sweep, group carry-ins (c0 folded into every group), sum and flags ----
    always_comb begin
        pre_g = up_g_p1_q;
        pre_p = up_p_p1_q;
        for (int l = LOGN - 2; l >= 0; l--) begin
            for (int i = 0; i < NG; i++) begin
                if (i >= (1 << (l + 1)) && ((i + 1) % (1 << (l + 1))) == (1 << l)) begin
                    {pre_g[i], pre_p[i]} = gp_dot({pre_g[i], pre_p[i]},
                        {pre_g[i-(1<<l)], pre_p[i-(1<<l)]});
                end
            end
        end
        cin_grp    = '0;
        cin_grp[0] = c0_p1_q;
        for (int i = 1; i < NG; i++) begin
            cin_grp[i] = pre_g[i-1] | (pre_p[i-1] & c0_p1_q);
        end
        gen_s2   = a_p1_q & b_p1_q;
        prop_s2  = a_p1_q ^ b_p1_q;
        carry_s2 = '0;
        for (int g = 0; g < NG; g++) begin
            for (int k = 0; k < GROUPSIZE; k++) begin
                if (k == 0) begin
                    carry_s2[g*GROUPSIZE] = cin_grp[g];
                end else begin
                    carry_s2[g*GROUPSIZE+k] = gen_s2[g*GROUPSIZE+k-1]
                        | (prop_s2[g*GROUPSIZE+k-1] & carry_s2[g*GROUPSIZE+k-1]);
                end
            end
        end
        sum_p2_d  = prop_s2 ^ carry_s2;
        cout_p2_d = pre_g[NG-1] | (pre_p[NG-1] & c0_p1_q);
        ovf_p2_d  = (a_p1_q[WIDTH-1] == b_p1_q[WIDTH-1]) && (sum_p2_d[WIDTH-1] != a_p1_q[WIDTH-1]);
        zero_p2_d = (sum_p2_d == '0);
    end

    // Outputs only change when a real result lands, so they hold while out_valid is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2_q  <= 1'b0;
            sum_p2_q  <= '0;
            cout_p2_q <= 1'b0;
            ovf_p2_q  <= 1'b0;
            zero_p2_q <= 1'b0;
            tag_p2_q  <= '0;
        end else begin
            vld_p2_q <= vld_p2_d;
            if (adv2 && vld_p1_q) begin
                sum_p2_q  <= sum_p2_d;
                cout_p2_q <= cout_p2_d;
                ovf_p2_q  <= ovf_p2_d;
                zero_p2_q <= zero_p2_d;
                tag_p2_q  <= tag_p1_q;
            end
        end
    end

    assign out_valid = vld_p2_q;
    assign out_sum   = sum_p2_q;
    assign out_cout  = cout_p2_q;
    assign out_ovf   = ovf_p2_q;
    assign out_zero  = zero_p2_q;
    assign out_tag   = tag_p2_q;
endmodule
